// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR engine: width limits, feedback mode and tap masks.
package lfsr_pkg;

  localparam int N_MIN = 2;
  localparam int N_MAX = 32;

  typedef enum logic {
    FIB    = 1'b0,
    GALOIS = 1'b1
  } lfsr_mode_e;

  // Maximal-length tap mask for an n-bit LFSR; bit k set means term x^(k+1).
  function automatic logic [31:0] TAPS(input int n);
    logic [31:0] t;
    case (n)
      2:       t = 32'h0000_0003;
      3:       t = 32'h0000_0006;
      4:       t = 32'h0000_000C;
      5:       t = 32'h0000_0014;
      6:       t = 32'h0000_0030;
      7:       t = 32'h0000_0060;
      8:       t = 32'h0000_00B8;
      9:       t = 32'h0000_0110;
      10:      t = 32'h0000_0240;
      11:      t = 32'h0000_0500;
      12:      t = 32'h0000_0829;
      13:      t = 32'h0000_100D;
      14:      t = 32'h0000_2015;
      15:      t = 32'h0000_6000;
      16:      t = 32'h0000_D008;
      17:      t = 32'h0001_2000;
      18:      t = 32'h0002_0400;
      19:      t = 32'h0004_0023;
      20:      t = 32'h0009_0000;
      21:      t = 32'h0014_0000;
      22:      t = 32'h0030_0000;
      23:      t = 32'h0042_0000;
      24:      t = 32'h00E1_0000;
      25:      t = 32'h0120_0000;
      26:      t = 32'h0200_0023;
      27:      t = 32'h0400_0013;
      28:      t = 32'h0900_0000;
      29:      t = 32'h1400_0000;
      30:      t = 32'h2000_0029;
      31:      t = 32'h4800_0000;
      32:      t = 32'h8020_0003;
      default: t = 32'h0000_0000;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/lfsr_period_tracker.sv
// Counts steps since the last seed load or seed match, and reports the cycle
// length with a one-cycle done pulse whenever the sequence returns to the seed.
module lfsr_period_tracker
  import lfsr_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [N-1:0] seed_i,
  input  logic         step_i,
  input  logic [N-1:0] next_state_i,
  output logic [N-1:0] period_o,
  output logic         done_o
);

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  logic [N-1:0] seed_q,   seed_d;
  logic [N-1:0] cnt_q,    cnt_d;
  logic [N-1:0] period_q, period_d;
  logic         done_q,   done_d;
  logic [N-1:0] cnt_inc_s;
  logic         match_s;

  // Next-state for the counter, latched seed, period and done pulse.
  always_comb begin
    seed_d    = seed_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    done_d    = 1'b0;
    // Saturate so the counter can never wrap back to zero on its own.
    cnt_inc_s = (cnt_q == {N{1'b1}}) ? cnt_q : cnt_q + ONE;
    match_s   = (next_state_i == seed_q);
    if (load_i) begin
      seed_d = seed_i;
      cnt_d  = '0;
    end else if (step_i) begin
      if (match_s) begin
        period_d = cnt_inc_s;
        cnt_d    = '0;
        done_d   = 1'b1;
      end else begin
        cnt_d = cnt_inc_s;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Tracker registers; reset forgets any pending done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      seed_q   <= ONE;
      cnt_q    <= '0;
      period_q <= '0;
      done_q   <= 1'b0;
    end else begin
      seed_q   <= seed_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      done_q   <= done_d;
    end
  end

  assign period_o = period_q;
  assign done_o   = done_q;

endmodule

// File: rtl/lfsr_engine.sv
// N-bit LFSR with selectable Fibonacci/Galois feedback, seed loading and
// period measurement. An all-zero seed is replaced by 1 and flagged.
module lfsr_engine
  import lfsr_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_seed,
  input  logic [N-1:0] seed_data,
  input  logic         galois_sel,
  input  logic         step_en,
  output logic [N-1:0] lfsr_data,
  output logic         lfsr_done,
  output logic [N-1:0] period,
  output logic         seed_err
);

  if ((N < N_MIN) || (N > N_MAX)) begin : g_width_check
    $error("lfsr_engine: N=%0d outside supported range", N);
  end

  localparam logic [31:0]  P_FULL = TAPS(N);
  localparam logic [N-1:0] P      = P_FULL[N-1:0];
  localparam logic [N-1:0] ONE    = {{(N-1){1'b0}}, 1'b1};

  logic [N-1:0] state_q, state_d;
  lfsr_mode_e   mode_q,  mode_d;
  logic         err_q,   err_d;
  logic [N-1:0] fib_next_s;
  logic [N-1:0] gal_next_s;
  logic [N-1:0] step_next_s;
  logic [N-1:0] load_val_s;
  logic         do_step_s;

  // Feedback network and next-state selection (load beats step, step beats hold).
  always_comb begin
    fib_next_s  = {state_q[N-2:0], ^(state_q & P)};
    gal_next_s  = {state_q[N-2:0], 1'b0} ^
                  (state_q[N-1] ? {P[N-2:0], 1'b1} : {N{1'b0}});
    step_next_s = (mode_q == GALOIS) ? gal_next_s : fib_next_s;
    load_val_s  = (seed_data == '0) ? ONE : seed_data;
    do_step_s   = step_en & ~load_seed;
    state_d     = state_q;
    mode_d      = mode_q;
    err_d       = 1'b0;
    if (load_seed) begin
      state_d = load_val_s;
      mode_d  = galois_sel ? GALOIS : FIB;
      err_d   = (seed_data == '0);
    end else if (step_en) begin
      state_d = step_next_s;
    end else begin
      state_d = state_q;
    end
  end

  // State, mode and seed-error registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ONE;
      mode_q  <= FIB;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
    end
  end

  lfsr_period_tracker #(.N(N)) u_tracker (
    .clk          (clk),
    .reset        (reset),
    .load_i       (load_seed),
    .seed_i       (load_val_s),
    .step_i       (do_step_s),
    .next_state_i (step_next_s),
    .period_o     (period),
    .done_o       (lfsr_done)
  );

  assign lfsr_data = state_q;
  assign seed_err  = err_q;

endmodule

// File: tb/tb_lfsr_engine.sv
// Self-checking bench: N=4 and N=8 engines against a polynomial-arithmetic model.
module tb_lfsr_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst4, ld4, gs4, se4, done4, err4;
  logic [3:0] sd4, dat4, per4;
  logic       rst8, ld8, gs8, se8, done8, err8;
  logic [7:0] sd8, dat8, per8;

  lfsr_engine #(.N(4)) u4 (
    .clk(clk), .reset(rst4), .load_seed(ld4), .seed_data(sd4), .galois_sel(gs4),
    .step_en(se4), .lfsr_data(dat4), .lfsr_done(done4), .period(per4), .seed_err(err4)
  );

  lfsr_engine #(.N(8)) u8 (
    .clk(clk), .reset(rst8), .load_seed(ld8), .seed_data(sd8), .galois_sel(gs8),
    .step_en(se8), .lfsr_data(dat8), .lfsr_done(done8), .period(per8), .seed_err(err8)
  );

  typedef struct {
    int st; int seed; int gal; int cnt; int per; int done; int err;
  } mdl_t;

  mdl_t m4, m8;
  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Multiply by x modulo the characteristic polynomial (Galois), or shift in tap parity (Fibonacci).
  function automatic int adv(input int s, input int n, input int taps, input int gal);
    int mask;
    int q;
    int r;
    mask = (1 << n) - 1;
    if (gal != 0) begin
      q = (1 << n) | ((taps << 1) & mask) | 1;
      r = s << 1;
      if (((r >> n) & 1) != 0) r = r ^ q;
    end else begin
      r = (s << 1) | ($countones(s & taps) % 2);
    end
    return r & mask;
  endfunction

  function automatic mdl_t mdl_next(input mdl_t m, input int n, input int taps,
                                    input int rst, input int ld, input int sd,
                                    input int gs, input int se);
    mdl_t r;
    int   v;
    int   mx;
    r      = m;
    r.done = 0;
    r.err  = 0;
    mx     = (1 << n) - 1;
    if (rst != 0) begin
      r.st = 1; r.seed = 1; r.gal = 0; r.cnt = 0; r.per = 0;
    end else if (ld != 0) begin
      v = sd & mx;
      r.err = (v == 0) ? 1 : 0;
      if (v == 0) v = 1;
      r.st = v; r.seed = v; r.gal = gs; r.cnt = 0;
    end else if (se != 0) begin
      v = adv(m.st, n, taps, m.gal);
      r.st = v;
      if (v == m.seed) begin
        r.done = 1; r.per = m.cnt + 1; r.cnt = 0;
      end else begin
        r.cnt = (m.cnt + 1 > mx) ? mx : m.cnt + 1;
      end
    end
    return r;
  endfunction

  task automatic check_both();
    check("dat4",  dat4,  m4.st);
    check("done4", done4, m4.done);
    check("per4",  per4,  m4.per);
    check("err4",  err4,  m4.err);
    check("dat8",  dat8,  m8.st);
    check("done8", done8, m8.done);
    check("per8",  per8,  m8.per);
    check("err8",  err8,  m8.err);
  endtask

  // One clock cycle: drive the selected engine, idle the other, then compare both.
  task automatic cyc(input int sel, input int rst, input int ld, input int sd,
                     input int gs, input int se);
    rst4 = 1'b0; ld4 = 1'b0; sd4 = 4'h0; gs4 = 1'b0; se4 = 1'b0;
    rst8 = 1'b0; ld8 = 1'b0; sd8 = 8'h00; gs8 = 1'b0; se8 = 1'b0;
    if (sel == 4) begin
      rst4 = rst[0]; ld4 = ld[0]; sd4 = sd[3:0]; gs4 = gs[0]; se4 = se[0];
    end else begin
      rst8 = rst[0]; ld8 = ld[0]; sd8 = sd[7:0]; gs8 = gs[0]; se8 = se[0];
    end
    @(posedge clk);
    if (sel == 4) begin
      m4 = mdl_next(m4, 4, 'hC, rst, ld, sd, gs, se);
      m8 = mdl_next(m8, 8, 'hB8, 0, 0, 0, 0, 0);
    end else begin
      m4 = mdl_next(m4, 4, 'hC, 0, 0, 0, 0, 0);
      m8 = mdl_next(m8, 8, 'hB8, rst, ld, sd, gs, se);
    end
    #1;
    check_both();
  endtask

  logic [3:0] fib_exp [4] = '{4'h2, 4'h4, 4'h9, 4'h3};
  logic [3:0] gal_exp [5] = '{4'h2, 4'h4, 4'h8, 4'h9, 4'hB};

  initial begin
    int steps;
    int seen;
    int sel;

    // Reset both engines together.
    rst4 = 1'b1; ld4 = 1'b0; sd4 = 4'h0; gs4 = 1'b0; se4 = 1'b0;
    rst8 = 1'b1; ld8 = 1'b0; sd8 = 8'h00; gs8 = 1'b0; se8 = 1'b0;
    @(posedge clk);
    m4 = mdl_next(m4, 4, 'hC, 1, 0, 0, 0, 0);
    m8 = mdl_next(m8, 8, 'hB8, 1, 0, 0, 0, 0);
    #1;
    check_both();
    check("rst_dat4", dat4, 4'h1);
    check("rst_per8", per8, 8'h00);

    // N=4 Fibonacci from seed 1.
    cyc(4, 0, 1, 1, 0, 0);
    for (int i = 1; i <= 15; i++) begin
      cyc(4, 0, 0, 0, 0, 1);
      if (i <= 4) check("fib4_seq", dat4, fib_exp[i-1]);
      if (i == 14) check("fib4_nodone", done4, 1'b0);
    end
    check("fib4_done", done4, 1'b1);
    check("fib4_period", per4, 4'd15);
    cyc(4, 0, 0, 0, 0, 0);
    check("fib4_pulse_once", done4, 1'b0);

    // N=4 Galois from seed 1.
    cyc(4, 0, 1, 1, 1, 0);
    for (int i = 1; i <= 15; i++) begin
      cyc(4, 0, 0, 0, 0, 1);
      if (i <= 5) check("gal4_seq", dat4, gal_exp[i-1]);
    end
    check("gal4_done", done4, 1'b1);
    check("gal4_period", per4, 4'd15);

    // Zero seed is replaced by 1 and flagged once.
    cyc(4, 0, 1, 0, 0, 0);
    check("zero_err", err4, 1'b1);
    check("zero_dat", dat4, 4'h1);
    for (int i = 1; i <= 15; i++) begin
      cyc(4, 0, 0, 0, 0, 1);
      if (i == 1) check("zero_err_once", err4, 1'b0);
    end
    check("zero_period", per4, 4'd15);

    // Load together with step mid-run: load only, counter restarts.
    cyc(4, 0, 1, 1, 0, 0);
    for (int i = 0; i < 7; i++) cyc(4, 0, 0, 0, 0, 1);
    cyc(4, 0, 1, 8, 0, 1);
    check("ldstep_dat", dat4, 4'h8);
    check("ldstep_nodone", done4, 1'b0);
    for (int i = 1; i <= 15; i++) cyc(4, 0, 0, 0, 0, 1);
    check("ldstep_done", done4, 1'b1);
    check("ldstep_period", per4, 4'd15);

    // Reset mid-run, including on the cycle that would have produced done.
    cyc(4, 0, 1, 1, 0, 0);
    for (int i = 0; i < 14; i++) cyc(4, 0, 0, 0, 0, 1);
    cyc(4, 1, 0, 0, 0, 1);
    check("rst_kills_done", done4, 1'b0);
    check("rst_mid_dat", dat4, 4'h1);
    check("rst_mid_per", per4, 4'h0);
    cyc(4, 0, 0, 0, 0, 1);
    check("rst_first_step", dat4, 4'h2);

    // N=8 Fibonacci, seed A5, random step enables.
    cyc(8, 0, 1, 'hA5, 0, 0);
    steps = 0;
    seen  = 0;
    for (int i = 0; i < 2000 && seen == 0; i++) begin
      int en;
      en = int'($urandom_range(1, 0));
      cyc(8, 0, 0, 0, 0, en);
      if (en != 0) steps++;
      if (done8 === 1'b1) seen = 1;
    end
    check("n8_done_seen", seen, 1);
    check("n8_steps", steps, 255);
    check("n8_period", per8, 8'd255);

    // N=8 Galois full period.
    cyc(8, 0, 1, 'h3C, 1, 0);
    for (int i = 1; i <= 255; i++) cyc(8, 0, 0, 0, 0, 1);
    check("n8g_done", done8, 1'b1);
    check("n8g_period", per8, 8'd255);

    // Random mix on both engines.
    for (int i = 0; i < 1200; i++) begin
      int r;
      int l;
      int s;
      sel = ($urandom_range(1, 0) == 0) ? 4 : 8;
      r   = ($urandom_range(199, 0) == 0) ? 1 : 0;
      l   = ($urandom_range(39, 0) == 0) ? 1 : 0;
      s   = ($urandom_range(3, 0) == 0) ? 0 : int'($urandom);
      cyc(sel, r, l, s, int'($urandom_range(1, 0)),
          ($urandom_range(3, 0) != 0) ? 1 : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/lfsr_engine.md
LFSR_ENGINE -- requirements
Module: lfsr_engine

Interface
REQ-001 Parameter N, default 8, LFSR width; legal range 2..32, with any other value rejected by an elaboration-time assertion.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 load_seed  in  1  loads seed_data and galois_sel, and restarts period tracking.
REQ-005 seed_data  in  N  seed value.
REQ-006 galois_sel  in  1  feedback mode, latched only on load_seed: 0 = Fibonacci, 1 = Galois.
REQ-007 step_en  in  1  advances the LFSR one step when high; holds state when low.
REQ-008 lfsr_data  out  N  current LFSR state, registered.
REQ-009 lfsr_done  out  1  one-cycle pulse when the state returns to the latched seed.
REQ-010 period  out  N  step count at the most recent lfsr_done, registered.
REQ-011 seed_err  out  1  one-cycle pulse when an all-zero seed was loaded.

Function
REQ-012 Polynomial mask: P = TAPS(N) from the package, maximal-length, bit k set for term x^(k+1).
REQ-013 Fibonacci step: state <= {state[N-2:0], ^(state & P)}.
REQ-014 Galois step: state <= {state[N-2:0],1'b0} ^ (state[N-1] ? {P[N-2:0],1'b1} : 0).
REQ-015 Operation priority per cycle: reset > load_seed > step_en > hold.
REQ-016 Load: state <= seed_data; seed_reg <= seed_data; mode <= galois_sel; step_cnt <= 0.
REQ-017 An all-zero seed loads 1 into state and seed_reg instead, and seed_err pulses in the following cycle.
REQ-018 Each step increments step_cnt (N bits).
REQ-019 If next_state == seed_reg on a step: lfsr_done pulses in the following cycle, period <= step_cnt+1, and step_cnt <= 0.
REQ-020 step_cnt saturates at 2^N-1; it never wraps to 0 without a seed match.
REQ-021 Counting and the done check continue across any number of cycles with step_en=0.
REQ-022 load_seed and step_en asserted together performs a load only; no step and no done pulse.
REQ-023 lfsr_done and seed_err are never asserted for more than one consecutive cycle without a new qualifying event.
REQ-024 The state never becomes all-zero in either mode.
REQ-025 lfsr_data updates in the cycle after a load or step, a latency of 1.

Reset
REQ-026 On reset: state=1, seed_reg=1, mode=Fibonacci, step_cnt=0, period=0, lfsr_done=0, seed_err=0.
REQ-027 Reset mid-sequence discards any pending done and err pulses, and the first step after reset starts from state 1.

Structure
REQ-028 Package lfsr_pkg holds: the TAPS(N) function returning a 32-bit maximal-length mask for N=2..32; the lfsr_mode_e enum (FIB, GALOIS); and the N_MIN/N_MAX constants.
REQ-029 TAPS entries for small N: 2->0011, 3->0110, 4->1100, 5->10100, 6->110000, 7->1100000, 8->10111000.
REQ-030 Sub-module lfsr_period_tracker holds step_cnt, the seed compare, period, and lfsr_done generation; the top holds state, mode, and the feedback logic.

Verification
REQ-031 N=4, Fibonacci, seed 0001, step_en=1 -> lfsr_data 0010, 0100, 1001, 0011, ...; lfsr_done pulses after step 15 with period=15.
REQ-032 N=4, Galois, seed 0001 -> lfsr_data 0010, 0100, 1000, 1001, 1011; done after 15 steps with period=15.
REQ-033 N=4, load seed 0000 -> seed_err pulses once, lfsr_data=0001, and a full run gives period=15.
REQ-034 N=8, Fibonacci, seed A5, step_en toggled randomly -> done after exactly 255 enabled steps, period=255.
REQ-035 Mid-run (step 7 of 15): load_seed and step_en together with seed 1000 -> lfsr_data=1000 next cycle, no done pulse, step_cnt restarts at 0.
REQ-036 Mid-run: reset asserted for one cycle -> all outputs take their REQ-026 values on the next edge, and the next step yields 0010 (N=4, Fibonacci).
